lp_pwr_seq: RTL and testbench
=============================

# lp_pwr_seq

Power-sequencing controller sitting directly upstream of `design_top`. It drives the domain power switch `top_pwr_sw` together with the isolation and retention controls that the switchable domain needs. It accepts single power-up and power-down requests from the system and handshakes with the switch acknowledge. It enforces the ordering isolate → save → switch off, and switch on → restore → de-isolate, with programmable delays and an acknowledge timeout.

## Interface
- `ISO_DLY`, default 2: cycles isolation is held before SAVE and after RESTORE; legal range 1..15.
- `SAVE_CYCLES`, default 1: cycles `save` is held high; legal range 1..15.
- `ACK_TIMEOUT`, default 16: maximum cycles to wait for `sw_ack` in SW_ON or SW_OFF; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pwr_up_req` in 1: power-up request, sampled each edge.
- `pwr_down_req` in 1: power-down request, sampled each edge.
- `sw_ack` in 1: switch acknowledge; 1 means domain powered.
- `top_pwr_sw` out 1: power switch enable to `design_top`.
- `iso_en` out 1: isolation enable; domain outputs clamped when 1.
- `save` out 1: retention save strobe.
- `restore` out 1: retention restore strobe.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse when ON or OFF is reached.
- `err` out 1: acknowledge timeout, sticky.
- `state` out 4: current state encoding, for debug and coverage.

## Operation
- States: OFF, SW_ON, RESTORE, DE_ISO, ON, ISO, SAVE, SW_OFF, ERR.
- All outputs are Moore outputs, decoded from the registered state (plus the registered `done` flag).
- Reset: state = OFF; `top_pwr_sw`=0, `iso_en`=1, `save`=0, `restore`=0, `busy`=0, `done`=0, `err`=0.
- Reset asserted mid-sequence returns the block to OFF on the next edge, whatever the previous state.
- OFF: if `pwr_up_req`=1, go to SW_ON; otherwise `pwr_down_req` is ignored.
- SW_ON:
  - `top_pwr_sw`=1.
  - If `sw_ack`=1, go to RESTORE.
  - If ACK_TIMEOUT cycles elapse without the acknowledge, go to ERR.
- RESTORE: `restore`=1 for exactly 1 cycle, then go to DE_ISO.
- DE_ISO: `iso_en` stays 1 for ISO_DLY cycles, then go to ON.
- ON: `iso_en`=0, `top_pwr_sw`=1. If `pwr_down_req`=1, go to ISO; otherwise `pwr_up_req` is ignored.
- ISO: `iso_en`=1 for ISO_DLY cycles, then go to SAVE.
- SAVE: `save`=1 for SAVE_CYCLES cycles, then go to SW_OFF.
- SW_OFF:
  - `top_pwr_sw`=0.
  - If `sw_ack`=0, go to OFF.
  - If ACK_TIMEOUT cycles elapse, go to ERR.
- ERR:
  - `top_pwr_sw`=0, `iso_en`=1, `err`=1.
  - Leaves only on `rst`; all requests are ignored.
- `iso_en`=1 in every state except ON.
- `top_pwr_sw`=1 in SW_ON, RESTORE, DE_ISO, ON and ISO/SAVE.
- Requests arriving outside ON/OFF are dropped, not queued. Both requests high together: only the one legal in the current state acts.
- `busy`=1 in all states except ON, OFF and ERR.
- `done` pulses 1 cycle in the first cycle of ON or OFF. It does not pulse on reset entry into OFF.

## Timing
- A request sampled at edge k moves the state at edge k, so outputs change in the cycle after the request is seen.
- Power-down, with `pwr_down_req` seen at edge k:
  - ISO occupies edges k .. k+ISO_DLY−1.
  - SAVE occupies k+ISO_DLY .. k+ISO_DLY+SAVE_CYCLES−1.
  - SW_OFF is entered at k+ISO_DLY+SAVE_CYCLES.
- Ack wait: `sw_ack` at the target level at the first SW_ON/SW_OFF edge exits in 1 cycle.
- Timeout counter:
  - Loaded on entry to SW_ON or SW_OFF.
  - ERR is taken at the edge where ACK_TIMEOUT cycles have been spent without the acknowledge.
  - Acknowledge and timeout on the same edge: the acknowledge wins.
- Delay counter: down-counter loaded to the phase length minus 1 on entry; the state advances when it reads 0.
- Counter width: $clog2(256) = 8 bits, shared by all phases.

## Structure
- Shared package `lp_ctrl_pkg`:
  - enum `pwr_state_e` (4-bit), with OFF=0, ON=4 and ERR=8.
  - Default delay constants.
- Sub-module `lp_dly_cnt`: loadable 8-bit down-counter with `load`, `value` and `zero`. One instance serves the ISO/SAVE/DE_ISO delays, one serves the acknowledge timeout.
- FSM, output decode and `done` generation live in `lp_pwr_seq`.

## Test plan
- Reset, then `pwr_up_req` pulse with `sw_ack` rising 3 cycles later (defaults):
  - `top_pwr_sw`=1 one cycle after the request.
  - `restore` high 1 cycle.
  - `iso_en` falls 2 cycles after `restore`.
  - `done` pulses; state=ON.
- From ON, `pwr_down_req` pulse:
  - `iso_en`=1, then `save` high 1 cycle 2 cycles later, then `top_pwr_sw`=0.
  - `sw_ack` drops → OFF with a `done` pulse.
- `sw_ack` held 0 in SW_ON: ERR after exactly 16 cycles; `err`=1, `top_pwr_sw`=0, `iso_en`=1. A subsequent `pwr_up_req` has no effect; `rst` restores OFF.
- `pwr_up_req` and `pwr_down_req` pulsed during SAVE and DE_ISO: sequence timing unchanged, no extra transitions. Both requests high in ON: power-down proceeds.
- `rst` asserted during SAVE: next edge gives state=OFF, `save`=0, `top_pwr_sw`=0, `iso_en`=1, `done`=0.
- `sw_ack` rising on the same edge the timeout expires: RESTORE taken, `err` stays 0.

Source files
------------

// File: rtl/lp_ctrl_pkg.sv
// lp_ctrl_pkg: shared state encoding and default timing constants for the power sequencer
package lp_ctrl_pkg;
    localparam int CNT_W           = $clog2(256);
    localparam int ISO_DLY_DEF     = 2;
    localparam int SAVE_CYCLES_DEF = 1;
    localparam int ACK_TIMEOUT_DEF = 16;
    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_SW_ON   = 4'd1,
        ST_RESTORE = 4'd2,
        ST_DE_ISO  = 4'd3,
        ST_ON      = 4'd4,
        ST_ISO     = 4'd5,
        ST_SAVE    = 4'd6,
        ST_SW_OFF  = 4'd7,
        ST_ERR     = 4'd8
    } pwr_state_e;
endpackage

// File: rtl/lp_dly_cnt.sv
// lp_dly_cnt: loadable down-counter that parks at zero
// Ports: clk, rst (sync, active-high), load strobes value into the counter,
// zero is high while the count reads 0.
module lp_dly_cnt
    import lp_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/lp_pwr_seq.sv
// lp_pwr_seq: power switch / isolation / retention sequencer for design_top
// Ports: clk, rst (sync, active-high); pwr_up_req, pwr_down_req requests;
// sw_ack switch acknowledge; top_pwr_sw, iso_en, save, restore controls;
// busy, done (one-cycle on reaching ON/OFF), err (sticky timeout); state debug.
module lp_pwr_seq
    import lp_ctrl_pkg::*;
#(
    parameter int ISO_DLY     = ISO_DLY_DEF,
    parameter int SAVE_CYCLES = SAVE_CYCLES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_up_req,
    input  logic       pwr_down_req,
    input  logic       sw_ack,
    output logic       top_pwr_sw,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] state
);
    pwr_state_e cur, nxt;
    logic dly_zero, tmo_zero, entry;
    always_comb begin
        nxt = cur;
        case (cur)
            ST_OFF:     nxt = pwr_up_req ? ST_SW_ON : ST_OFF;
            // acknowledge is tested first so it wins over a same-edge timeout
            ST_SW_ON:   nxt = sw_ack ? ST_RESTORE : tmo_zero ? ST_ERR : ST_SW_ON;
            ST_RESTORE: nxt = ST_DE_ISO;
            ST_DE_ISO:  nxt = dly_zero ? ST_ON : ST_DE_ISO;
            ST_ON:      nxt = pwr_down_req ? ST_ISO : ST_ON;
            ST_ISO:     nxt = dly_zero ? ST_SAVE : ST_ISO;
            ST_SAVE:    nxt = dly_zero ? ST_SW_OFF : ST_SAVE;
            ST_SW_OFF:  nxt = !sw_ack ? ST_OFF : tmo_zero ? ST_ERR : ST_SW_OFF;
            default:    nxt = ST_ERR;
        endcase
    end
    // counters are loaded with phase length - 1 as the state is entered
    assign entry = nxt != cur;
    lp_dly_cnt u_dly (
        .clk   (clk),
        .rst   (rst),
        .load  (entry && (nxt inside {ST_DE_ISO, ST_ISO, ST_SAVE})),
        .value (nxt == ST_SAVE ? CNT_W'(SAVE_CYCLES - 1) : CNT_W'(ISO_DLY - 1)),
        .zero  (dly_zero)
    );
    lp_dly_cnt u_tmo (
        .clk   (clk),
        .rst   (rst),
        .load  (entry && (nxt inside {ST_SW_ON, ST_SW_OFF})),
        .value (CNT_W'(ACK_TIMEOUT - 1)),
        .zero  (tmo_zero)
    );
    always_ff @(posedge clk)
        if (rst) begin
            cur  <= ST_OFF;
            done <= 1'b0;
        end else begin
            cur  <= nxt;
            done <= entry && (nxt == ST_ON || nxt == ST_OFF);
        end
    assign top_pwr_sw = cur inside {ST_SW_ON, ST_RESTORE, ST_DE_ISO, ST_ON, ST_ISO, ST_SAVE};
    assign iso_en     = cur != ST_ON;
    assign save       = cur == ST_SAVE;
    assign restore    = cur == ST_RESTORE;
    assign busy       = !(cur inside {ST_OFF, ST_ON, ST_ERR});
    assign err        = cur == ST_ERR;
    assign state      = cur;
endmodule

// File: tb/tb_lp_pwr_seq.sv
// tb_lp_pwr_seq: directed and random checks of lp_pwr_seq against a phase/elapsed-time model
module tb_lp_pwr_seq;
    localparam int ISO_DLY = 2, SAVE_CYCLES = 1, ACK_TIMEOUT = 16;
    logic clk = 0, rst = 1, pwr_up_req = 0, pwr_down_req = 0, sw_ack = 0;
    logic top_pwr_sw, iso_en, save, restore, busy, done, err;
    logic [3:0] state;
    int errors = 0, checks = 0;
    typedef enum {P_OFF, P_SW_ON, P_RESTORE, P_DE_ISO, P_ON, P_ISO, P_SAVE, P_SW_OFF, P_ERR} ph_e;
    ph_e ph = P_OFF;
    int spent = 0;
    logic mdone = 0;

    lp_pwr_seq #(.ISO_DLY(ISO_DLY), .SAVE_CYCLES(SAVE_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pwr_up_req(pwr_up_req), .pwr_down_req(pwr_down_req), .sw_ack(sw_ack),
        .top_pwr_sw(top_pwr_sw), .iso_en(iso_en), .save(save), .restore(restore),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic go(input ph_e p);
        ph = p;
        spent = 0;
        mdone = (p == P_ON || p == P_OFF);
    endtask

    // model: each phase lasts a number of elapsed cycles taken from the rules
    task automatic model_step(input logic r, input logic u, input logic d, input logic a);
        mdone = 0;
        if (r) begin
            ph = P_OFF;
            spent = 0;
            return;
        end
        spent++;
        case (ph)
            P_OFF:     if (u) go(P_SW_ON);
            P_SW_ON:   if (a) go(P_RESTORE); else if (spent == ACK_TIMEOUT) go(P_ERR);
            P_RESTORE: go(P_DE_ISO);
            P_DE_ISO:  if (spent == ISO_DLY) go(P_ON);
            P_ON:      if (d) go(P_ISO);
            P_ISO:     if (spent == ISO_DLY) go(P_SAVE);
            P_SAVE:    if (spent == SAVE_CYCLES) go(P_SW_OFF);
            P_SW_OFF:  if (!a) go(P_OFF); else if (spent == ACK_TIMEOUT) go(P_ERR);
            default:   ;
        endcase
    endtask

    // {top_pwr_sw, iso_en, save, restore, busy, done, err}
    function automatic logic [6:0] exp_vec();
        return {ph inside {P_SW_ON, P_RESTORE, P_DE_ISO, P_ON, P_ISO, P_SAVE}, ph != P_ON,
                ph == P_SAVE, ph == P_RESTORE, !(ph inside {P_OFF, P_ON, P_ERR}), mdone, ph == P_ERR};
    endfunction

    function automatic bit state_ok();
        case (ph)
            P_OFF:   return state === 4'd0;
            P_ON:    return state === 4'd4;
            P_ERR:   return state === 4'd8;
            default: return !$isunknown(state) && !(state inside {4'd0, 4'd4, 4'd8});
        endcase
    endfunction

    task automatic tick(input logic r, input logic u, input logic d, input logic a);
        rst = r;
        pwr_up_req = u;
        pwr_down_req = d;
        sw_ack = a;
        @(posedge clk);
        model_step(r, u, d, a);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== 7'b0100000 || state !== 4'd0) begin
            errors++;
            $display("FAIL reset_values: outputs=%b state=%0d, expected 0100000 state=0", {top_pwr_sw, iso_en, save, restore, busy, done, err}, state);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1'($urandom_range(0, 1)), 0);
            if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== exp_vec() || !state_ok()) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs=%b state=%0d, expected %b in %s", i, {top_pwr_sw, iso_en, save, restore, busy, done, err}, state, exp_vec(), ph.name());
            end
            checks++;
        end
    endtask

    task automatic test_power_up();
        int rcnt = 0, dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, i == 0, 0, i >= 3);
            rcnt += int'(restore);
            dcnt += int'(done);
            if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== exp_vec() || !state_ok()) begin
                errors++;
                $display("FAIL power_up cycle %0d: outputs=%b state=%0d, expected %b in %s", i, {top_pwr_sw, iso_en, save, restore, busy, done, err}, state, exp_vec(), ph.name());
            end
            checks++;
        end
        if (rcnt != 1 || dcnt != 1 || state !== 4'd4) begin
            errors++;
            $display("FAIL power_up_summary: restore_cycles=%0d done_pulses=%0d state=%0d, expected 1 1 4", rcnt, dcnt, state);
        end
        checks++;
    endtask

    task automatic test_power_down();
        int scnt = 0, dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, i == 0, i < 5);
            scnt += int'(save);
            dcnt += int'(done);
            if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== exp_vec() || !state_ok()) begin
                errors++;
                $display("FAIL power_down cycle %0d: outputs=%b state=%0d, expected %b in %s", i, {top_pwr_sw, iso_en, save, restore, busy, done, err}, state, exp_vec(), ph.name());
            end
            checks++;
        end
        if (scnt != SAVE_CYCLES || dcnt != 1 || state !== 4'd0) begin
            errors++;
            $display("FAIL power_down_summary: save_cycles=%0d done_pulses=%0d state=%0d, expected %0d 1 0", scnt, dcnt, state, SAVE_CYCLES);
        end
        checks++;
    endtask

    task automatic test_timeout();
        int bcnt = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 26; i++) begin
            tick(0, i == 0 || i >= 21, i == 23, 0);
            bcnt += int'(busy);
            if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== exp_vec() || !state_ok()) begin
                errors++;
                $display("FAIL timeout cycle %0d: outputs=%b state=%0d, expected %b in %s", i, {top_pwr_sw, iso_en, save, restore, busy, done, err}, state, exp_vec(), ph.name());
            end
            checks++;
        end
        if (bcnt != ACK_TIMEOUT || err !== 1'b1 || state !== 4'd8) begin
            errors++;
            $display("FAIL timeout_summary: wait_cycles=%0d err=%b state=%0d, expected %0d 1 8", bcnt, err, state, ACK_TIMEOUT);
        end
        checks++;
        tick(1, 1, 0, 0);
        if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== 7'b0100000 || state !== 4'd0) begin
            errors++;
            $display("FAIL timeout_reset: outputs=%b state=%0d, expected 0100000 state=0", {top_pwr_sw, iso_en, save, restore, busy, done, err}, state);
        end
        checks++;
    endtask

    task automatic test_ack_at_timeout();
        int ecnt = 0, rcnt = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i <= ACK_TIMEOUT + ISO_DLY + 2; i++) begin
            tick(0, i == 0, 0, i >= ACK_TIMEOUT);
            ecnt += int'(err);
            rcnt += int'(restore);
            if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== exp_vec() || !state_ok()) begin
                errors++;
                $display("FAIL ack_at_timeout cycle %0d: outputs=%b state=%0d, expected %b in %s", i, {top_pwr_sw, iso_en, save, restore, busy, done, err}, state, exp_vec(), ph.name());
            end
            checks++;
        end
        if (ecnt != 0 || rcnt != 1 || state !== 4'd4) begin
            errors++;
            $display("FAIL ack_at_timeout_summary: err_cycles=%0d restore_cycles=%0d state=%0d, expected 0 1 4", ecnt, rcnt, state);
        end
        checks++;
    endtask

    task automatic test_midseq_reqs();
        int d1 = -1, d2 = -1;
        logic u, d;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            u = ph == P_OFF ? i == 0 : ph == P_ON ? i == 8 : 1'($urandom_range(0, 1));
            d = ph == P_ON ? i == 8 : 1'($urandom_range(0, 1));
            tick(0, u, d, i >= 2 && i < 14);
            if (done === 1'b1) begin
                if (d1 < 0) d1 = i; else d2 = i;
            end
            if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== exp_vec() || !state_ok()) begin
                errors++;
                $display("FAIL midseq_reqs cycle %0d: outputs=%b state=%0d, expected %b in %s", i, {top_pwr_sw, iso_en, save, restore, busy, done, err}, state, exp_vec(), ph.name());
            end
            checks++;
        end
        if (d1 != 3 + ISO_DLY || d2 != 14) begin
            errors++;
            $display("FAIL midseq_timeline: done at %0d and %0d, expected %0d and 14", d1, d2, 3 + ISO_DLY);
        end
        checks++;
    endtask

    task automatic test_rst_mid();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, i == 0, i == 7, 1);
            if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== exp_vec() || !state_ok()) begin
                errors++;
                $display("FAIL rst_mid cycle %0d: outputs=%b state=%0d, expected %b in %s", i, {top_pwr_sw, iso_en, save, restore, busy, done, err}, state, exp_vec(), ph.name());
            end
            checks++;
        end
        if (save !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_save: save=%b, expected 1", save);
        end
        checks++;
        tick(1, 0, 0, 1);
        if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== 7'b0100000 || state !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_reset: outputs=%b state=%0d, expected 0100000 state=0", {top_pwr_sw, iso_en, save, restore, busy, done, err}, state);
        end
        checks++;
    endtask

    task automatic test_random();
        logic ack_q = 0, stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) stuck = !stuck;
            if (!stuck && $urandom_range(0, 2) == 0) ack_q = top_pwr_sw;
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ack_q);
            if ({top_pwr_sw, iso_en, save, restore, busy, done, err} !== exp_vec() || !state_ok()) begin
                errors++;
                $display("FAIL random cycle %0d: outputs=%b state=%0d, expected %b in %s", i, {top_pwr_sw, iso_en, save, restore, busy, done, err}, state, exp_vec(), ph.name());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_timeout();
        test_ack_at_timeout();
        test_midseq_reqs();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
